// File: rtl/pov_refresh_scheduler.sv
// Refresh sequencer for the POV display: freezes a texture column per angle step and issues
// strip_start pulses with an enforced WS2812 latch gap. Optional macro: POV_FREE_RUN_EN.
module pov_refresh_scheduler #(
  parameter int THETA_BITS   = 6,
  parameter int TEX_WIDTH    = 256,
  parameter int LATCH_CYCLES = 5000,
  parameter int TIMEOUT      = 65535,
  parameter int CNT_BITS     = 16,
  localparam int COL_BITS    = $clog2(TEX_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [THETA_BITS-1:0] theta,
  input  logic                  theta_valid,
  input  logic                  strip_done,
  output logic                  strip_start,
  output logic [COL_BITS-1:0]   col,
  output logic                  busy,
  output logic [CNT_BITS-1:0]   refresh_cnt,
  output logic [CNT_BITS-1:0]   overrun_cnt,
  output logic                  stall
);

  localparam int LAT_BITS  = (LATCH_CYCLES > 2) ? $clog2(LATCH_CYCLES) : 1;
  localparam int TMR_BITS  = $clog2(TIMEOUT + 1);
  localparam int PROD_BITS = THETA_BITS + COL_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t                state_r;
  state_t                next_state_s;
  logic [THETA_BITS-1:0] last_theta_r;
  logic [THETA_BITS-1:0] prev_theta_r;
  logic                  pending_r;
  logic [LAT_BITS-1:0]   latch_cnt_r;
  logic [TMR_BITS-1:0]   timer_r;
  logic [PROD_BITS-1:0]  prod_s;
  logic                  theta_chg_s;
  logic                  trigger_s;
  logic                  timeout_s;
  logic                  start_d_s;
  logic                  busy_d_s;
  logic                  launch_s;

  assign prod_s      = PROD_BITS'(theta) * PROD_BITS'(TEX_WIDTH);
  assign theta_chg_s = (theta != prev_theta_r);
  assign timeout_s   = (timer_r == TMR_BITS'(TIMEOUT - 1));

`ifdef POV_FREE_RUN_EN
  // Without a locked angle, refresh continuously so the strip can be brought up stationary.
  assign trigger_s = theta_valid ? ((theta != last_theta_r) || pending_r) : 1'b1;
`else
  assign trigger_s = theta_valid && ((theta != last_theta_r) || pending_r);
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= LATCH;
    else       state_r <= next_state_s;
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:    if (trigger_s) next_state_s = START; else next_state_s = IDLE;
      START:   next_state_s = SHIFT;
      SHIFT:   if (strip_done || timeout_s) next_state_s = LATCH; else next_state_s = SHIFT;
      LATCH:   if (latch_cnt_r == LAT_BITS'(0)) next_state_s = IDLE; else next_state_s = LATCH;
      default: next_state_s = LATCH;
    endcase
  end

  // Output decode; busy follows next_state so the registered copy lines up with state_r
  always_comb begin
    start_d_s = (state_r == START);
    busy_d_s  = (next_state_s != IDLE);
    launch_s  = (state_r == IDLE) && trigger_s;
  end

  // Datapath, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      strip_start  <= 1'b0;
      col          <= COL_BITS'(0);
      busy         <= 1'b1;
      refresh_cnt  <= CNT_BITS'(0);
      overrun_cnt  <= CNT_BITS'(0);
      stall        <= 1'b0;
      last_theta_r <= THETA_BITS'(0);
      prev_theta_r <= THETA_BITS'(0);
      pending_r    <= 1'b0;
      latch_cnt_r  <= LAT_BITS'(LATCH_CYCLES - 1);
      timer_r      <= TMR_BITS'(0);
    end else begin
      strip_start  <= start_d_s;
      busy         <= busy_d_s;
      prev_theta_r <= theta;

      if (launch_s) begin
        pending_r <= 1'b0;
        if (theta_valid) begin
          col          <= prod_s[PROD_BITS-1:THETA_BITS];
          last_theta_r <= theta;
        end
      end else if ((state_r != IDLE) && theta_chg_s) begin
        if (!pending_r) pending_r <= 1'b1;
        else if (overrun_cnt != {CNT_BITS{1'b1}}) overrun_cnt <= overrun_cnt + CNT_BITS'(1);
      end

      if (state_r == START)      timer_r <= TMR_BITS'(0);
      else if (state_r == SHIFT) timer_r <= timer_r + TMR_BITS'(1);

      if (state_r == SHIFT) begin
        if (strip_done)     refresh_cnt <= refresh_cnt + CNT_BITS'(1);
        else if (timeout_s) stall <= 1'b1;
      end

      // Reload on LATCH entry so the gap is always LATCH_CYCLES long
      if ((next_state_s == LATCH) && (state_r != LATCH))
        latch_cnt_r <= LAT_BITS'(LATCH_CYCLES - 1);
      else if ((state_r == LATCH) && (latch_cnt_r != LAT_BITS'(0)))
        latch_cnt_r <= latch_cnt_r - LAT_BITS'(1);
    end
  end

endmodule
